// File: rtl/asrv32_sequencer_pkg.sv
// Shared encodings for the ASRV32 multi-cycle sequencer: opcode bit indices,
// state/PC-select/cause codes and small decode helpers.
package asrv32_sequencer_pkg;

  localparam int OPCODE_WIDTH = 11;

  localparam int RTYPE  = 0;
  localparam int ITYPE  = 1;
  localparam int LOAD   = 2;
  localparam int STORE  = 3;
  localparam int BRANCH = 4;
  localparam int JAL    = 5;
  localparam int JALR   = 6;
  localparam int LUI    = 7;
  localparam int AUIPC  = 8;
  localparam int SYSTEM = 9;
  localparam int FENCE  = 10;

  typedef enum logic [2:0] {
    SEQ_FETCH     = 3'd0,
    SEQ_DECODE    = 3'd1,
    SEQ_EXECUTE   = 3'd2,
    SEQ_MEMORY    = 3'd3,
    SEQ_WRITEBACK = 3'd4,
    SEQ_TRAP      = 3'd5
  } seq_state_e;

  typedef enum logic [1:0] {
    PC_NEXT   = 2'b00,
    PC_TARGET = 2'b01,
    PC_JALR   = 2'b10,
    PC_TRAP   = 2'b11
  } pc_sel_e;

  localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
  localparam logic [3:0] CAUSE_EBREAK      = 4'd3;
  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_ECALL       = 4'd11;

  localparam logic [OPCODE_WIDTH-1:0] OPCODE_ONE = {{(OPCODE_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic is_onehot(input logic [OPCODE_WIDTH-1:0] op);
    return (op != {OPCODE_WIDTH{1'b0}}) && ((op & (op - OPCODE_ONE)) == {OPCODE_WIDTH{1'b0}});
  endfunction

  // CSR ops (SYSTEM with funct3 != 0) write rd; ECALL/EBREAK never reach writeback.
  function automatic logic writes_rd(input logic [OPCODE_WIDTH-1:0] op, input logic csr_op);
    return op[RTYPE] | op[ITYPE] | op[LOAD] | op[JAL] | op[JALR] |
           op[LUI] | op[AUIPC] | (op[SYSTEM] & csr_op);
  endfunction

endpackage

// File: rtl/asrv32_sequencer.sv
// Multi-cycle control FSM for the ASRV32 core: fetch/decode/execute/memory/
// writeback stepping, trap generation and retired-instruction counting.
module asrv32_sequencer
  import asrv32_sequencer_pkg::*;
#(
  parameter bit TRAP_ON_FENCE = 1'b0
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [OPCODE_WIDTH-1:0] i_opcode,
  input  logic [2:0]              i_funct3,
  input  logic                    i_imm0,
  input  logic                    i_branch_taken,
  input  logic                    i_mem_misaligned,
  output logic                    o_inst_req,
  input  logic                    i_inst_ack,
  output logic                    o_decode_ce,
  output logic                    o_alu_ce,
  output logic                    o_data_req,
  output logic                    o_data_we,
  input  logic                    i_data_ack,
  output logic                    o_rd_we,
  output logic                    o_pc_ce,
  output logic [1:0]              o_pc_sel,
  output logic                    o_trap,
  output logic [3:0]              o_trap_cause,
  output logic [31:0]             o_instret,
  output logic [2:0]              o_state
);

  seq_state_e              state_q,   state_d;
  logic [OPCODE_WIDTH-1:0] op_q,      op_d;
  logic                    taken_q,   taken_d;
  logic                    csr_q,     csr_d;
  logic [3:0]              cause_q,   cause_d;
  logic [31:0]             instret_q, instret_d;

  // Next-state logic; the opcode class and branch outcome are captured in EXECUTE.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    taken_d   = taken_q;
    csr_d     = csr_q;
    cause_d   = cause_q;
    instret_d = instret_q;
    case (state_q)
      SEQ_FETCH: begin
        if (i_inst_ack) state_d = SEQ_DECODE;
        else            state_d = SEQ_FETCH;
      end
      SEQ_DECODE: state_d = SEQ_EXECUTE;
      SEQ_EXECUTE: begin
        op_d    = i_opcode;
        taken_d = i_branch_taken;
        csr_d   = (i_funct3 != 3'd0);
        if (!is_onehot(i_opcode) || (i_opcode[FENCE] && TRAP_ON_FENCE)) begin
          state_d = SEQ_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else if (i_opcode[SYSTEM] && (i_funct3 == 3'd0)) begin
          state_d = SEQ_TRAP;
          cause_d = i_imm0 ? CAUSE_EBREAK : CAUSE_ECALL;
        end else if ((i_opcode[LOAD] || i_opcode[STORE]) && i_mem_misaligned) begin
          state_d = SEQ_TRAP;
          cause_d = i_opcode[LOAD] ? CAUSE_LD_MISALIGN : CAUSE_ST_MISALIGN;
        end else if (i_opcode[LOAD] || i_opcode[STORE]) begin
          state_d = SEQ_MEMORY;
        end else begin
          state_d = SEQ_WRITEBACK;
        end
      end
      SEQ_MEMORY: begin
        if (i_data_ack) state_d = SEQ_WRITEBACK;
        else            state_d = SEQ_MEMORY;
      end
      SEQ_WRITEBACK: begin
        instret_d = instret_q + 32'd1;
        state_d   = SEQ_FETCH;
      end
      SEQ_TRAP: state_d = SEQ_FETCH;
      default:  state_d = SEQ_FETCH;
    endcase
  end

  // State and bookkeeping registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= SEQ_FETCH;
      op_q      <= {OPCODE_WIDTH{1'b0}};
      taken_q   <= 1'b0;
      csr_q     <= 1'b0;
      cause_q   <= 4'd0;
      instret_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      taken_q   <= taken_d;
      csr_q     <= csr_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end

  // Moore output decode; reset masks everything so requests drop in the same cycle.
  always_comb begin
    o_inst_req   = 1'b0;
    o_decode_ce  = 1'b0;
    o_alu_ce     = 1'b0;
    o_data_req   = 1'b0;
    o_data_we    = 1'b0;
    o_rd_we      = 1'b0;
    o_pc_ce      = 1'b0;
    o_pc_sel     = PC_NEXT;
    o_trap       = 1'b0;
    o_trap_cause = 4'd0;
    o_instret    = 32'd0;
    o_state      = 3'd0;
    if (i_rst_n) begin
      o_state      = state_q;
      o_trap_cause = cause_q;
      o_instret    = instret_q;
      case (state_q)
        SEQ_FETCH:   o_inst_req  = 1'b1;
        SEQ_DECODE:  o_decode_ce = 1'b1;
        SEQ_EXECUTE: o_alu_ce    = 1'b1;
        SEQ_MEMORY: begin
          o_data_req = 1'b1;
          o_data_we  = op_q[STORE];
        end
        SEQ_WRITEBACK: begin
          o_pc_ce = 1'b1;
          o_rd_we = writes_rd(op_q, csr_q);
          if (op_q[JALR])                             o_pc_sel = PC_JALR;
          else if (op_q[JAL] || (op_q[BRANCH] && taken_q)) o_pc_sel = PC_TARGET;
          else                                        o_pc_sel = PC_NEXT;
        end
        SEQ_TRAP: begin
          o_trap   = 1'b1;
          o_pc_ce  = 1'b1;
          o_pc_sel = PC_TRAP;
        end
        default: o_inst_req = 1'b0;
      endcase
    end else begin
      o_state = 3'd0;
    end
  end

endmodule

// File: tb/tb_asrv32_sequencer.sv
// Directed scoreboard bench for asrv32_sequencer: per-cycle expected outputs
// are queued as stimulus is applied and compared on the falling edge.
module tb_asrv32_sequencer;
  import asrv32_sequencer_pkg::*;

  logic                    i_clk = 1'b0;
  logic                    i_rst_n;
  logic [OPCODE_WIDTH-1:0] i_opcode;
  logic [2:0]              i_funct3;
  logic                    i_imm0;
  logic                    i_branch_taken;
  logic                    i_mem_misaligned;
  logic                    i_inst_ack;
  logic                    i_data_ack;
  logic                    o_inst_req, o_decode_ce, o_alu_ce, o_data_req, o_data_we;
  logic                    o_rd_we, o_pc_ce, o_trap;
  logic [1:0]              o_pc_sel;
  logic [3:0]              o_trap_cause;
  logic [31:0]             o_instret;
  logic [2:0]              o_state;

  asrv32_sequencer dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_opcode(i_opcode), .i_funct3(i_funct3),
    .i_imm0(i_imm0), .i_branch_taken(i_branch_taken), .i_mem_misaligned(i_mem_misaligned),
    .o_inst_req(o_inst_req), .i_inst_ack(i_inst_ack), .o_decode_ce(o_decode_ce),
    .o_alu_ce(o_alu_ce), .o_data_req(o_data_req), .o_data_we(o_data_we),
    .i_data_ack(i_data_ack), .o_rd_we(o_rd_we), .o_pc_ce(o_pc_ce), .o_pc_sel(o_pc_sel),
    .o_trap(o_trap), .o_trap_cause(o_trap_cause), .o_instret(o_instret), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [2:0]  st;
    logic        ireq, dce, ace, dreq, dwe, rdwe, pcce;
    logic [1:0]  psel;
    logic        trap;
    logic [3:0]  cause;
    logic [31:0] ir;
  } obs_t;

  obs_t  sb_q[$];
  string tag_q[$];
  int    n_cmp = 0;
  int    n_mis = 0;
  logic [3:0]  exp_cause = 4'd0;
  logic [31:0] exp_instret = 32'd0;

  task automatic push(input string tag, input logic [2:0] st, input logic ireq, input logic dce,
                      input logic ace, input logic dreq, input logic dwe, input logic rdwe,
                      input logic pcce, input logic [1:0] psel, input logic trap);
    obs_t e;
    e = '{st, ireq, dce, ace, dreq, dwe, rdwe, pcce, psel, trap, exp_cause, exp_instret};
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic push_reset(input string tag);
    obs_t e;
    e = '0;
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Compare the oldest queued expectation against the DUT, then advance one cycle.
  task automatic tick();
    obs_t  e, o;
    string t;
    #1;
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    o = '{o_state, o_inst_req, o_decode_ce, o_alu_ce, o_data_req, o_data_we, o_rd_we,
          o_pc_ce, o_pc_sel, o_trap, o_trap_cause, o_instret};
    n_cmp++;
    assert (o === e) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", t, o, e);
    end
    @(negedge i_clk);
  endtask

  task automatic do_insn(input string tag, input logic [OPCODE_WIDTH-1:0] op,
                         input logic [2:0] f3, input logic imm0, input logic taken,
                         input logic mis, input int iw, input int dw, input logic noise);
    logic       trap_k, mem_k, rd_k;
    logic [3:0] c_k;
    logic [1:0] ps_k;
    trap_k = 1'b1;
    c_k    = 4'd0;
    if (!$onehot(op))                           c_k = 4'd2;
    else if (op[SYSTEM] && f3 == 3'd0)          c_k = imm0 ? 4'd3 : 4'd11;
    else if ((op[LOAD] || op[STORE]) && mis)    c_k = op[LOAD] ? 4'd4 : 4'd6;
    else                                        trap_k = 1'b0;
    mem_k = op[LOAD] | op[STORE];
    rd_k  = op[RTYPE] | op[ITYPE] | op[LOAD] | op[JAL] | op[JALR] | op[LUI] | op[AUIPC] |
            (op[SYSTEM] && f3 != 3'd0);
    ps_k  = op[JALR] ? 2'b10 : ((op[JAL] || (op[BRANCH] && taken)) ? 2'b01 : 2'b00);

    i_opcode = op; i_funct3 = f3; i_imm0 = imm0;
    i_branch_taken = taken; i_mem_misaligned = mis;
    for (int k = 0; k <= iw; k++) begin
      i_inst_ack = (k == iw);
      i_data_ack = noise;
      push({tag, "_fetch"}, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
      tick();
    end
    i_inst_ack = noise;
    push({tag, "_decode"}, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    tick();
    push({tag, "_execute"}, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    tick();
    if (trap_k) begin
      exp_cause = c_k;
      push({tag, "_trap"}, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1);
      tick();
    end else begin
      if (mem_k) begin
        for (int k = 0; k <= dw; k++) begin
          i_data_ack = (k == dw);
          push({tag, "_memory"}, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, op[STORE], 1'b0, 1'b0, 2'b00, 1'b0);
          tick();
        end
        i_data_ack = noise;
      end
      push({tag, "_writeback"}, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rd_k, 1'b1, ps_k, 1'b0);
      tick();
      exp_instret = exp_instret + 32'd1;
    end
    i_inst_ack = 1'b0;
    i_data_ack = 1'b0;
  endtask

  function automatic logic [OPCODE_WIDTH-1:0] oh(input int idx);
    logic [OPCODE_WIDTH-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  initial begin
    logic [OPCODE_WIDTH-1:0] bad;
    i_rst_n = 1'b0; i_opcode = '0; i_funct3 = 3'd0; i_imm0 = 1'b0;
    i_branch_taken = 1'b0; i_mem_misaligned = 1'b0; i_inst_ack = 1'b0; i_data_ack = 1'b0;
    @(negedge i_clk);
    push_reset("reset_0"); tick();
    push_reset("reset_1"); tick();
    i_rst_n = 1'b1;

    do_insn("add",        oh(RTYPE),  3'd0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    do_insn("lw_wait3",   oh(LOAD),   3'd2, 1'b0, 1'b0, 1'b0, 0, 3, 1'b0);
    do_insn("sw_misalgn", oh(STORE),  3'd2, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
    do_insn("beq_taken",  oh(BRANCH), 3'd0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    do_insn("ecall",      oh(SYSTEM), 3'd0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    do_insn("ebreak",     oh(SYSTEM), 3'd0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    do_insn("opcode_0",   '0,         3'd0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    bad = oh(RTYPE) | oh(LOAD);
    do_insn("opcode_2hot", bad,       3'd0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    do_insn("lw_misalgn", oh(LOAD),   3'd2, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
    do_insn("sw_noise",   oh(STORE),  3'd2, 1'b0, 1'b1, 1'b0, 2, 1, 1'b1);
    do_insn("bne_ntaken", oh(BRANCH), 3'd1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b1);
    do_insn("fence_nop",  oh(FENCE),  3'd0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    do_insn("csrrw",      oh(SYSTEM), 3'd1, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0);
    do_insn("jal",        oh(JAL),    3'd0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    do_insn("lui",        oh(LUI),    3'd0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);

    // Preload the retired count to all-ones while parked in FETCH.
    i_inst_ack = 1'b0;
    force dut.instret_q = 32'hFFFF_FFFF;
    exp_instret = 32'hFFFF_FFFF;
    push("preload_fetch", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    tick();
    release dut.instret_q;
    do_insn("jalr_wrap",  oh(JALR),   3'd0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    do_insn("addi",       oh(ITYPE),  3'd0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);

    // Reset while a load waits in MEMORY.
    i_opcode = oh(LOAD); i_mem_misaligned = 1'b0; i_data_ack = 1'b0;
    i_inst_ack = 1'b1;
    push("rst_lw_fetch", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0); tick();
    i_inst_ack = 1'b0;
    push("rst_lw_decode", 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0); tick();
    push("rst_lw_exec", 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0); tick();
    push("rst_lw_mem", 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0); tick();
    i_rst_n = 1'b0;
    exp_instret = 32'd0;
    exp_cause = 4'd0;
    push_reset("rst_mask"); tick();
    push_reset("rst_held"); tick();
    i_rst_n = 1'b1;
    push("rst_release", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0); tick();
    do_insn("auipc_after", oh(AUIPC), 3'd0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
